key_loader_32: RTL and testbench

- Upstream feeder for the 32-key-bit RLL-locked combinational netlists: fetches the unlock key from a byte-wide key-store interface and drives the 32 keyIn_0_* lines of the locked core.
- Assembles the key beat by beat, checks a trailing checksum beat, and publishes the key only when it verifies.
- Until a verified key is loaded, the core sees an all-zero key and stays locked, producing corrupted outputs.

---
 rtl/key_loader_32_if.sv | 25 ++
 rtl/key_loader_32.sv | 123 ++++++++++++
 tb/tb_key_loader_32.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/key_loader_32_if.sv
// Key-store beat bus plus the key/status lines of the loader.
// The master side is the key-store/requester; the slave side is the loader.
interface key_loader_32_if #(
  parameter int KEY_WIDTH  = 32,
  parameter int BEAT_WIDTH = 8
);
  logic                  load_start;
  logic                  src_valid;
  logic [BEAT_WIDTH-1:0] src_data;
  logic                  src_ready;
  logic [KEY_WIDTH-1:0]  key_out;
  logic                  key_valid;
  logic                  load_busy;
  logic                  load_error;

  modport master (
    output load_start, src_valid, src_data,
    input  src_ready, key_out, key_valid, load_busy, load_error
  );

  modport slave (
    input  load_start, src_valid, src_data,
    output src_ready, key_out, key_valid, load_busy, load_error
  );
endinterface

// File: rtl/key_loader_32.sv
// Fetches the unlock key beat by beat, verifies a trailing additive checksum and
// only then publishes it to the locked core; the core sees zero until then.
module key_loader_32 #(
  parameter int KEY_WIDTH      = 32,
  parameter int BEAT_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic            clk,
  input logic            rst,
  key_loader_32_if.slave bus
);
  localparam int NBEATS = KEY_WIDTH / BEAT_WIDTH;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);
  localparam logic [15:0]      TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CSUM, DONE, ERROR} state_t;

  state_t                state;
  logic [KEY_WIDTH-1:0]  shadow;
  logic [KEY_WIDTH-1:0]  key_out;
  logic [CNT_W-1:0]      beat_cnt;
  logic [BEAT_WIDTH-1:0] acc;
  logic [15:0]           tmo_cnt;
  logic                  src_ready;
  logic                  key_valid;
  logic                  load_busy;
  logic                  load_error;
  logic                  accept;

  function automatic logic [BEAT_WIDTH-1:0] csum_add(input logic [BEAT_WIDTH-1:0] a,
                                                     input logic [BEAT_WIDTH-1:0] b);
    csum_add = a + b;
  endfunction

  // src_ready is registered and high only in LOAD/CSUM, so it alone gates acceptance.
  assign accept = bus.src_valid && src_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shadow     <= '0;
      key_out    <= '0;
      beat_cnt   <= '0;
      acc        <= '0;
      tmo_cnt    <= '0;
      src_ready  <= 1'b0;
      key_valid  <= 1'b0;
      load_busy  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (bus.load_start) begin
            state      <= LOAD;
            shadow     <= '0;
            key_out    <= '0;
            beat_cnt   <= '0;
            acc        <= '0;
            tmo_cnt    <= '0;
            src_ready  <= 1'b1;
            key_valid  <= 1'b0;
            load_busy  <= 1'b1;
            load_error <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            for (int k = 0; k < NBEATS; k++) begin
              if (beat_cnt == CNT_W'(k)) shadow[k*BEAT_WIDTH +: BEAT_WIDTH] <= bus.src_data;
            end
            acc     <= csum_add(acc, bus.src_data);
            tmo_cnt <= '0;
            if (beat_cnt == LAST_BEAT) state <= CSUM;
            else                       beat_cnt <= beat_cnt + 1'b1;
          end else if (tmo_cnt == TMO_LAST) begin
            state      <= ERROR;
            key_out    <= '0;
            src_ready  <= 1'b0;
            key_valid  <= 1'b0;
            load_busy  <= 1'b0;
            load_error <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        CSUM: begin
          if (accept) begin
            tmo_cnt   <= '0;
            src_ready <= 1'b0;
            load_busy <= 1'b0;
            if (bus.src_data == acc) begin
              state     <= DONE;
              key_out   <= shadow;
              key_valid <= 1'b1;
            end else begin
              state      <= ERROR;
              key_out    <= '0;
              key_valid  <= 1'b0;
              load_error <= 1'b1;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state      <= ERROR;
            key_out    <= '0;
            src_ready  <= 1'b0;
            key_valid  <= 1'b0;
            load_busy  <= 1'b0;
            load_error <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.src_ready  = src_ready;
  assign bus.key_out    = key_out;
  assign bus.key_valid  = key_valid;
  assign bus.load_busy  = load_busy;
  assign bus.load_error = load_error;
endmodule

// File: tb/tb_key_loader_32.sv
// Directed bench for key_loader_32 (timeout shortened to 4 cycles).
module tb_key_loader_32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  key_loader_32_if #(.KEY_WIDTH(32), .BEAT_WIDTH(8)) bus ();

  key_loader_32 #(.KEY_WIDTH(32), .BEAT_WIDTH(8), .TIMEOUT_CYCLES(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // status nibble: {key_valid, load_busy, load_error, src_ready}
  logic [3:0] status;
  assign status = {bus.key_valid, bus.load_busy, bus.load_error, bus.src_ready};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d);
    bus.src_valid = 1'b1;
    bus.src_data  = d;
    tick();
    bus.src_valid = 1'b0;
    bus.src_data  = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (status !== 4'b0000) begin
      errors++; $display("FAIL reset_status: got %b expected %b", status, 4'b0000);
    end
    checks++;
    if (bus.key_out !== 32'h0) begin
      errors++; $display("FAIL reset_key: got %h expected %h", bus.key_out, 32'h0);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_ok();
    start_load();
    checks++;
    if (status !== 4'b0101) begin
      errors++; $display("FAIL ok_loading_status: got %b expected %b", status, 4'b0101);
    end
    send_beat(8'h78); send_beat(8'h56); send_beat(8'h34); send_beat(8'h12);
    checks++;
    if (bus.key_valid !== 1'b0 || bus.key_out !== 32'h0) begin
      errors++; $display("FAIL ok_before_csum: got valid=%b key=%h expected valid=0 key=00000000", bus.key_valid, bus.key_out);
    end
    send_beat(8'h14);
    checks++;
    if (bus.key_out !== 32'h12345678) begin
      errors++; $display("FAIL ok_key: got %h expected %h", bus.key_out, 32'h12345678);
    end
    checks++;
    if (status !== 4'b1000) begin
      errors++; $display("FAIL ok_done_status: got %b expected %b", status, 4'b1000);
    end
    tick(); tick(); tick();
    checks++;
    if (bus.key_out !== 32'h12345678 || status !== 4'b1000) begin
      errors++; $display("FAIL ok_hold: got key=%h status=%b expected key=12345678 status=1000", bus.key_out, status);
    end
  endtask

  task automatic test_bad_csum();
    start_load();
    checks++;
    if (bus.key_out !== 32'h0 || bus.key_valid !== 1'b0) begin
      errors++; $display("FAIL bad_clear: got key=%h valid=%b expected key=00000000 valid=0", bus.key_out, bus.key_valid);
    end
    send_beat(8'h78); send_beat(8'h56); send_beat(8'h34); send_beat(8'h12);
    send_beat(8'h15);
    checks++;
    if (status !== 4'b0010) begin
      errors++; $display("FAIL bad_status: got %b expected %b", status, 4'b0010);
    end
    checks++;
    if (bus.key_out !== 32'h0) begin
      errors++; $display("FAIL bad_key: got %h expected %h", bus.key_out, 32'h0);
    end
  endtask

  task automatic test_timeout();
    start_load();
    checks++;
    if (status !== 4'b0101) begin
      errors++; $display("FAIL tmo_restart_status: got %b expected %b", status, 4'b0101);
    end
    send_beat(8'hA1); send_beat(8'hB2);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (status !== 4'b0101) begin
        errors++; $display("FAIL tmo_wait_%0d: got %b expected %b", i, status, 4'b0101);
      end
    end
    tick();
    checks++;
    if (status !== 4'b0010) begin
      errors++; $display("FAIL tmo_fire: got %b expected %b", status, 4'b0010);
    end
    bus.src_valid = 1'b1;
    bus.src_data  = 8'h5A;
    tick();
    bus.src_valid = 1'b0;
    checks++;
    if (status !== 4'b0010 || bus.key_out !== 32'h0) begin
      errors++; $display("FAIL tmo_after: got status=%b key=%h expected status=0010 key=00000000", status, bus.key_out);
    end
  endtask

  task automatic test_reload();
    start_load();
    send_beat(8'h78); send_beat(8'h56); send_beat(8'h34); send_beat(8'h12);
    send_beat(8'h14);
    checks++;
    if (bus.key_out !== 32'h12345678 || bus.key_valid !== 1'b1) begin
      errors++; $display("FAIL reload_first: got key=%h valid=%b expected key=12345678 valid=1", bus.key_out, bus.key_valid);
    end
    start_load();
    checks++;
    if (bus.key_out !== 32'h0 || bus.key_valid !== 1'b0) begin
      errors++; $display("FAIL reload_clear: got key=%h valid=%b expected key=00000000 valid=0", bus.key_out, bus.key_valid);
    end
    send_beat(8'hDD); send_beat(8'hCC); send_beat(8'hBB); send_beat(8'hAA);
    send_beat(8'h0E);
    checks++;
    if (bus.key_out !== 32'hAABBCCDD || status !== 4'b1000) begin
      errors++; $display("FAIL reload_key: got key=%h status=%b expected key=aabbccdd status=1000", bus.key_out, status);
    end
  endtask

  task automatic test_toggle();
    logic [7:0] beats [5];
    beats = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h0A};
    start_load();
    for (int i = 0; i < 5; i++) begin
      send_beat(beats[i]);
      // idle cycle with junk data; a stray load_start lands here after beat 1
      bus.src_valid  = 1'b0;
      bus.src_data   = 8'hFF;
      bus.load_start = (i == 1);
      tick();
      bus.load_start = 1'b0;
    end
    checks++;
    if (bus.key_out !== 32'h01020304) begin
      errors++; $display("FAIL toggle_key: got %h expected %h", bus.key_out, 32'h01020304);
    end
    checks++;
    if (status !== 4'b1000) begin
      errors++; $display("FAIL toggle_status: got %b expected %b", status, 4'b1000);
    end
  endtask

  task automatic test_rst_mid();
    start_load();
    send_beat(8'h11); send_beat(8'h22);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (status !== 4'b0000 || bus.key_out !== 32'h0) begin
      errors++; $display("FAIL rst_mid: got status=%b key=%h expected status=0000 key=00000000", status, bus.key_out);
    end
    bus.src_valid = 1'b1;
    bus.src_data  = 8'h99;
    tick(); tick(); tick();
    checks++;
    if (status !== 4'b0000) begin
      errors++; $display("FAIL idle_ignore: got %b expected %b", status, 4'b0000);
    end
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    bus.src_valid  = 1'b0;
    send_beat(8'h44); send_beat(8'h33); send_beat(8'h22); send_beat(8'h11);
    send_beat(8'hAA);
    checks++;
    if (bus.key_out !== 32'h11223344 || status !== 4'b1000) begin
      errors++; $display("FAIL rst_reload: got key=%h status=%b expected key=11223344 status=1000", bus.key_out, status);
    end
  endtask

  initial begin
    bus.load_start = 1'b0;
    bus.src_valid  = 1'b0;
    bus.src_data   = 8'h00;
    test_reset();
    test_load_ok();
    test_bad_csum();
    test_timeout();
    test_reload();
    test_toggle();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
